// File: rtl/hdmi_rx_pkg.sv
// Shared definitions for the HDMI receive path.
// Contents:
//   SymbolWidth / DataWidth - TMDS symbol and pixel component widths
//   TokenCtl00..TokenCtl11  - the four TMDS control-period tokens
//   rx_state_e              - channel alignment state (search / locked)
package hdmi_rx_pkg;

  localparam int unsigned SymbolWidth = 10;
  localparam int unsigned DataWidth   = 8;

  // Control tokens, indexed by the {C1,C0} value they carry.
  localparam logic [SymbolWidth-1:0] TokenCtl00 = 10'b1101010100;
  localparam logic [SymbolWidth-1:0] TokenCtl01 = 10'b0010101011;
  localparam logic [SymbolWidth-1:0] TokenCtl10 = 10'b0101010100;
  localparam logic [SymbolWidth-1:0] TokenCtl11 = 10'b1010101011;

  typedef enum logic {
    StSearch = 1'b0,
    StLocked = 1'b1
  } rx_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder, shared by all three colour channels.
// Ports:
//   sym_i      - aligned 10-bit TMDS symbol
//   is_token_o - symbol is one of the four control tokens
//   ctl_o      - {C1,C0} carried by the token (0 when not a token)
//   data_o     - 8-bit data decode (meaningful only when is_token_o = 0)
module tmds_symbol_decode
  import hdmi_rx_pkg::*;
(
  input  logic [SymbolWidth-1:0] sym_i,
  output logic                   is_token_o,
  output logic [1:0]             ctl_o,
  output logic [DataWidth-1:0]   data_o
);

  logic [DataWidth-1:0] t;

  always_comb begin
    is_token_o = 1'b1;
    ctl_o      = 2'b00;
    unique case (sym_i)
      TokenCtl00: ctl_o = 2'b00;
      TokenCtl01: ctl_o = 2'b01;
      TokenCtl10: ctl_o = 2'b10;
      TokenCtl11: ctl_o = 2'b11;
      default:    is_token_o = 1'b0;
    endcase
  end

  // Bit 9 flags an inverted payload, bit 8 selects XOR (1) or XNOR (0) chaining.
  always_comb begin
    t         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = '0;
    data_o[0] = t[0];
    for (int i = 1; i < DataWidth; i++) begin
      data_o[i] = sym_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment plus symbol decode.
// A 20-bit window over the last two raw words is searched for a run of
// LOCK_RUN control tokens at the current bit offset; after SLIP_WAIT cycles
// without one the offset slips by one bit. Once locked, every symbol is
// decoded to data (deOut=1) or control (deOut=0). Lock is dropped if no
// full token run is seen for LOCK_TIMEOUT cycles.
// Ports:
//   pixelClock    - sole clock
//   reset         - synchronous, active-high
//   symbolIn      - raw deserialized word, bit 0 received first
//   dataOut       - decoded pixel component (held during control periods)
//   ctlOut        - decoded {C1,C0} (held during data periods)
//   deOut         - 1 while dataOut carries a data-period value
//   locked        - symbol alignment acquired
//   bitOffset     - current alignment offset, 0..9
//   slipCount     - (TMDS_RX_STATS_EN only) saturating count of offset slips
//   lockLossCount - (TMDS_RX_STATS_EN only) saturating count of lock losses
// Optional feature macro: TMDS_RX_STATS_EN.
module tmds_channel_decoder
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned LOCK_RUN     = 8,
  parameter int unsigned SLIP_WAIT    = 2048,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                   pixelClock,
  input  logic                   reset,
  input  logic [SymbolWidth-1:0] symbolIn,
  output logic [DataWidth-1:0]   dataOut,
  output logic [1:0]             ctlOut,
  output logic                   deOut,
  output logic                   locked,
  output logic [3:0]             bitOffset
`ifdef TMDS_RX_STATS_EN
  ,
  output logic [7:0]             slipCount,
  output logic [7:0]             lockLossCount
`endif
);

  localparam int unsigned RunW  = $clog2(LOCK_RUN) + 1;
  localparam int unsigned WaitW = $clog2(SLIP_WAIT) + 1;
  localparam int unsigned ToW   = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RunW-1:0]  RunMax   = RunW'(LOCK_RUN);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(LOCK_TIMEOUT - 1);

  logic [SymbolWidth-1:0]   word_q, word2_q;
  logic [2*SymbolWidth-1:0] window;
  logic [4:0]               sel_idx;
  logic [SymbolWidth-1:0]   candidate;

  rx_state_e        state_q, state_d;
  logic [3:0]       offset_q, offset_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d, run_cnt_inc;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             run_full;
  logic             slip, lock_loss;

  logic [DataWidth-1:0] data_q, data_d;
  logic [1:0]           ctl_q, ctl_d;
  logic                 de_q, de_d;

  logic                 dec_is_token;
  logic [1:0]           dec_ctl;
  logic [DataWidth-1:0] dec_data;

  // Older word sits in the low half because bit 0 is received first.
  assign window    = {word_q, word2_q};
  assign sel_idx   = {1'b0, offset_q};
  assign candidate = window[sel_idx +: SymbolWidth];

  tmds_symbol_decode u_decode (
    .sym_i      (candidate),
    .is_token_o (dec_is_token),
    .ctl_o      (dec_ctl),
    .data_o     (dec_data)
  );

  // Token run length before any slip/timeout override; saturates at LOCK_RUN.
  assign run_cnt_inc = !dec_is_token       ? '0 :
                       (run_cnt_q == RunMax) ? run_cnt_q : run_cnt_q + 1'b1;
  assign run_full    = (run_cnt_inc == RunMax);

  // State register and counters.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      word_q     <= '0;
      word2_q    <= '0;
      state_q    <= StSearch;
      offset_q   <= '0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      data_q     <= '0;
      ctl_q      <= '0;
      de_q       <= 1'b0;
    end else begin
      word_q     <= symbolIn;
      word2_q    <= word_q;
      state_q    <= state_d;
      offset_q   <= offset_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      ctl_q      <= ctl_d;
      de_q       <= de_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    run_cnt_d  = run_cnt_inc;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    slip       = 1'b0;
    lock_loss  = 1'b0;
    unique case (state_q)
      StSearch: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A completed run wins over a slip due on the same cycle.
        if (run_full) begin
          state_d    = StLocked;
          wait_cnt_d = '0;
          to_cnt_d   = '0;
        end else if (wait_cnt_q == WaitLast) begin
          slip       = 1'b1;
          offset_d   = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          wait_cnt_d = '0;
          run_cnt_d  = '0;
        end
      end
      StLocked: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (run_full) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == ToLast) begin
          lock_loss  = 1'b1;
          state_d    = StSearch;
          run_cnt_d  = '0;
          wait_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Output next-state: zero while searching, token/data steering once locked.
  always_comb begin
    data_d = data_q;
    ctl_d  = ctl_q;
    de_d   = de_q;
    if (state_q == StLocked) begin
      if (dec_is_token) begin
        de_d  = 1'b0;
        ctl_d = dec_ctl;
      end else begin
        de_d   = 1'b1;
        data_d = dec_data;
      end
    end else begin
      data_d = '0;
      ctl_d  = '0;
      de_d   = 1'b0;
    end
  end

  assign dataOut   = data_q;
  assign ctlOut    = ctl_q;
  assign deOut     = de_q;
  assign locked    = (state_q == StLocked);
  assign bitOffset = offset_q;

`ifdef TMDS_RX_STATS_EN
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    slip_cnt_d = slip_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (slip && (slip_cnt_q != 8'hFF)) slip_cnt_d = slip_cnt_q + 8'd1;
    if (lock_loss && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      slip_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign slipCount     = slip_cnt_q;
  assign lockLossCount = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed self-checking bench for tmds_channel_decoder.
module tb_tmds_channel_decoder;

  localparam int unsigned LockRun     = 8;
  localparam int unsigned SlipWait    = 2048;
  localparam int unsigned LockTimeout = 4096;

  localparam logic [9:0] Tok0 = 10'b1101010100;
  localparam logic [9:0] Tok1 = 10'b0010101011;
  localparam logic [9:0] Tok2 = 10'b0101010100;
  localparam logic [9:0] Tok3 = 10'b1010101011;

  logic       pixelClock = 1'b0;
  logic       reset      = 1'b0;
  logic [9:0] symbolIn   = '0;
  logic [7:0] dataOut;
  logic [1:0] ctlOut;
  logic       deOut;
  logic       locked;
  logic [3:0] bitOffset;
`ifdef TMDS_RX_STATS_EN
  logic [7:0] slipCount;
  logic [7:0] lockLossCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Bit offset the transmitted stream is shifted by, and the previous symbol.
  int unsigned tx_off   = 0;
  logic [9:0]  prev_sym = '0;
  logic [9:0]  sym_a5;

  tmds_channel_decoder #(
    .LOCK_RUN     (LockRun),
    .SLIP_WAIT    (SlipWait),
    .LOCK_TIMEOUT (LockTimeout)
  ) dut (
    .pixelClock    (pixelClock),
    .reset         (reset),
    .symbolIn      (symbolIn),
    .dataOut       (dataOut),
    .ctlOut        (ctlOut),
    .deOut         (deOut),
    .locked        (locked),
    .bitOffset     (bitOffset)
`ifdef TMDS_RX_STATS_EN
    ,
    .slipCount     (slipCount),
    .lockLossCount (lockLossCount)
`endif
  );

  always #5 pixelClock = ~pixelClock;

  // Reference TMDS encoder without DC balancing: caller picks both flag bits.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic use_xor,
                                          input logic inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    end
    return {inv, use_xor, inv ? ~qm : qm};
  endfunction

  function automatic bit is_tok(input logic [9:0] s);
    return (s == Tok0) || (s == Tok1) || (s == Tok2) || (s == Tok3);
  endfunction

  task automatic tick();
    @(posedge pixelClock);
    #1;
  endtask

  // Transmit one symbol; the word boundary sits tx_off bits into the symbol.
  task automatic send(input logic [9:0] sym);
    logic [19:0] pair;
    pair     = {sym, prev_sym} >> (10 - tx_off);
    symbolIn = pair[9:0];
    prev_sym = sym;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if ({locked, bitOffset, deOut, ctlOut, dataOut} !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s: locked=%0b off=%0d de=%0b ctl=%0d data=%h, required all zero",
               tag, locked, bitOffset, deOut, ctlOut, dataOut);
    end
  endtask

  task automatic test_reset();
    symbolIn = '0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset_state");
  endtask

  task automatic test_aligned_lock();
    int lock_at = 0;
    do_reset();
    tx_off   = 0;
    prev_sym = Tok0;
    for (int i = 1; i <= 200; i++) begin
      send(Tok0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    n_checks++;
    if (lock_at == 0 || lock_at > int'(LockRun) + 3) begin
      n_fail++;
      $display("FAIL aligned_lock_time: locked after %0d symbols, required 1..%0d",
               lock_at, LockRun + 3);
    end
    n_checks++;
    if (bitOffset !== 4'd0) begin
      n_fail++;
      $display("FAIL aligned_offset: got %0d, required 0", bitOffset);
    end
    n_checks++;
    if (deOut !== 1'b0 || ctlOut !== 2'b00) begin
      n_fail++;
      $display("FAIL aligned_tokens: de=%0b ctl=%0d, required de=0 ctl=0", deOut, ctlOut);
    end
    for (int i = 0; i < 6; i++) send(sym_a5);
    n_checks++;
    if (deOut !== 1'b1 || dataOut !== 8'hA5 || ctlOut !== 2'b00) begin
      n_fail++;
      $display("FAIL aligned_data: de=%0b data=%h ctl=%0d, required de=1 data=a5 ctl=0",
               deOut, dataOut, ctlOut);
    end
  endtask

  task automatic test_tokens();
    logic [9:0] seq [6];
    logic [1:0] exp_ctl [4];
    seq     = '{Tok0, Tok1, Tok2, Tok3, Tok0, Tok0};
    exp_ctl = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      if (i >= 2) begin
        n_checks++;
        if (ctlOut !== exp_ctl[i-2] || deOut !== 1'b0) begin
          n_fail++;
          $display("FAIL token_%0d: ctl=%0d de=%0b, required ctl=%0d de=0",
                   i - 2, ctlOut, deOut, exp_ctl[i-2]);
        end
      end
    end
    n_checks++;
    if (dataOut !== 8'hA5) begin
      n_fail++;
      $display("FAIL token_data_hold: data=%h, required a5", dataOut);
    end
  endtask

  task automatic test_decode_sweep();
    logic [7:0] h0_v = '0, h1_v = '0;
    bit         h0_ok = 0, h1_ok = 0;
    logic [9:0] sym;
    for (int i = 0; i < 10; i++) send(Tok0);
    for (int v = 0; v < 256; v++) begin
      for (int p = 0; p < 4; p++) begin
        sym = tmds_enc(8'(v), p[0], p[1]);
        if (!is_tok(sym)) begin
          send(sym);
          if (h1_ok) begin
            n_checks++;
            if (dataOut !== h1_v || deOut !== 1'b1) begin
              n_fail++;
              $display("FAIL sweep_%h: data=%h de=%0b, required data=%h de=1",
                       h1_v, dataOut, deOut, h1_v);
            end
          end
          h1_v  = h0_v;
          h1_ok = h0_ok;
          h0_v  = 8'(v);
          h0_ok = 1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      send(Tok0);
      n_checks++;
      if (dataOut !== h1_v || deOut !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_tail_%h: data=%h de=%0b, required data=%h de=1",
                 h1_v, dataOut, deOut, h1_v);
      end
      h1_v = h0_v;
    end
  endtask

  task automatic test_lock_loss();
    int lock_at = 0;
    for (int i = 0; i < 10; i++) send(Tok0);
    for (int i = 0; i < int'(LockTimeout) - 6; i++) send(sym_a5);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_not_early: locked=%0b, required 1", locked);
    end
    for (int i = 0; i < 10; i++) send(sym_a5);
    check_idle("loss_dropped");
    for (int i = 1; i <= 20; i++) begin
      send(Tok0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    n_checks++;
    if (lock_at == 0 || lock_at > int'(LockRun) + 3 || bitOffset !== 4'd0) begin
      n_fail++;
      $display("FAIL relock: lock after %0d symbols off=%0d, required 1..%0d off=0",
               lock_at, bitOffset, LockRun + 3);
    end
  endtask

  // Lock onto a stream shifted by off bits; expected after off slips.
  task automatic lock_at_offset(input int unsigned off, input string tag);
    int lock_at = 0;
    int lo, hi;
    do_reset();
    tx_off   = off;
    prev_sym = Tok0;
    lo       = int'(off * SlipWait);
    hi       = lo + int'(LockRun) + 4;
    for (int i = 1; i <= hi + 50 && lock_at == 0; i++) begin
      send(Tok0);
      if (locked === 1'b1) lock_at = i;
    end
    n_checks++;
    if (lock_at < lo || lock_at > hi) begin
      n_fail++;
      $display("FAIL %s_lock_time: locked after %0d symbols, required %0d..%0d",
               tag, lock_at, lo, hi);
    end
    n_checks++;
    if (bitOffset !== 4'(off)) begin
      n_fail++;
      $display("FAIL %s_offset: got %0d, required %0d", tag, bitOffset, off);
    end
    for (int i = 0; i < 6; i++) send(sym_a5);
    n_checks++;
    if (dataOut !== 8'hA5 || deOut !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_data: data=%h de=%0b, required data=a5 de=1", tag, dataOut, deOut);
    end
  endtask

  task automatic test_misaligned();
    lock_at_offset(7, "misaligned");
  endtask

  task automatic test_reset_mid_locked();
    lock_at_offset(4, "midreset");
    reset = 1'b1;
    tick();
    check_idle("midreset_state");
    reset  = 1'b0;
    tx_off = 0;
  endtask

  initial begin
    sym_a5 = tmds_enc(8'hA5, 1'b1, 1'b0);
    test_reset();
    test_aligned_lock();
    test_tokens();
    test_decode_sweep();
    test_lock_loss();
    test_misaligned();
    test_reset_mid_locked();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS encoder/serializer channel.
- Accepts one raw 10-bit word per pixelClock from an upstream deserializer, with arbitrary bit alignment.
- Finds symbol alignment by hunting for runs of control tokens, then decodes each symbol to 8-bit data, or to a 2-bit control bus and DE.
- One instance per channel (blue/green/red) in a future hdmi_rx.

Parameters:
- LOCK_RUN, 8: consecutive identical-offset control tokens required to declare alignment.
- SLIP_WAIT, 2048: SEARCH cycles without reaching LOCK_RUN before slipping bit offset by one (must exceed one line period).
- LOCK_TIMEOUT, 4096: LOCKED cycles without a LOCK_RUN-long token run before dropping lock.

Ports:
- pixelClock  input  1  sole clock.
- reset  input  1  synchronous, active-high.
- symbolIn  input  10  raw deserialized word, bit 0 received first.
- dataOut  output  8  decoded pixel component.
- ctlOut  output  2  decoded control bits {C1,C0}.
- deOut  output  1  1 = dataOut valid (data period).
- locked  output  1  alignment acquired.
- bitOffset  output  4  current alignment offset, 0..9.

Behaviour:
- Interface: one clock (pixelClock); reset is synchronous and active-high.
- Reset: state=SEARCH, bitOffset=0, all counters=0, dataOut=0, ctlOut=0, deOut=0, locked=0, input pipeline cleared.
- Pipeline:
  - wordQ<=symbolIn; wordQQ<=wordQ; window={wordQ,wordQQ} (20 bits).
  - candidate=window[bitOffset+:10].
  - Outputs registered from candidate.
  - Fixed latency: a symbol on symbolIn at edge k, with bitOffset=0, appears on outputs after edge k+2.
- Token detect:
  - 10'b1101010100 -> ctl 00; 10'b0010101011 -> 01; 10'b0101010100 -> 10; 10'b1010101011 -> 11.
- Data decode:
  - q=candidate; t=q[9]?~q[7:0]:q[7:0]; d0=t0.
  - For i=1..7: d_i = q[8] ? t_i^t_(i-1) : ~(t_i^t_(i-1)).
- runCnt: increments on token, saturates at LOCK_RUN; clears on non-token or offset change.
- SEARCH:
  - waitCnt increments every cycle.
  - runCnt reaching LOCK_RUN -> LOCKED, waitCnt=0.
  - Else when waitCnt==SLIP_WAIT-1: bitOffset=(bitOffset==9)?0:bitOffset+1, waitCnt=0, runCnt=0.
  - Lock and slip on same cycle: lock wins, no slip.
  - Outputs held at 0 (deOut=0, locked=0).
- LOCKED:
  - locked=1.
  - Token -> deOut=0, ctlOut=token value, dataOut holds its last value.
  - Non-token -> deOut=1, dataOut=decoded, ctlOut holds.
  - toCnt increments every cycle; clears when runCnt reaches LOCK_RUN.
  - toCnt==LOCK_TIMEOUT-1 -> SEARCH with bitOffset kept, counters cleared, outputs zeroed next cycle.
- Offset change: takes effect on the next candidate; no output glitch is permitted while in SEARCH.
- Reset mid-operation: full return to the reset state on the next edge regardless of state.
- Counter widths: $clog2(param)+1; no wrap beyond saturation.

Optional Feature:
- Macro: TMDS_RX_STATS_EN.
- Defined: adds outputs slipCount[7:0] (slips in SEARCH) and lockLossCount[7:0] (LOCKED->SEARCH transitions). Both saturate at 255 and are cleared by reset.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package hdmi_rx_pkg holds:
  - the four control-token constants;
  - state enum {SEARCH, LOCKED};
  - symbol width 10 and data width 8.
- Sub-module tmds_symbol_decode (combinational): candidate -> {isToken, ctl[1:0], data[7:0]}. Reused for all three channels.

Test Plan:
- Aligned stream: 200 x token 10'b1101010100 then data symbols encoding 8'hA5, offset 0 -> locked=1 within LOCK_RUN+3 cycles, bitOffset=0, then deOut=1, dataOut=8'hA5, ctlOut=00 during tokens.
- Misaligned: same stream pre-rotated by 7 bits -> after 7 slips (~7xSLIP_WAIT cycles) locked=1, bitOffset=7, dataOut=8'hA5.
- All four tokens in sequence -> ctlOut 00,01,10,11 with deOut=0, each 3 edges after input.
- Decode sweep: encoder-reference symbols for all 256 values with both q[8] and q[9] polarities -> dataOut matches every value.
- Lock loss: after lock, feed LOCK_TIMEOUT cycles of data only -> locked falls, deOut=0, bitOffset unchanged; resume tokens -> relock without slip.
- Assert reset mid-LOCKED at offset 4 -> next edge locked=0, bitOffset=0, all outputs 0.
